// File: rtl/display_pkg.sv
// Shared definitions for the serial seven-segment display driver:
// scan FSM states, lit-high glyph codes and the shift word width.
package display_pkg;

  // Scan state machine states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_e;

  // Width of one shifted word: segment byte followed by digit-select byte
  localparam int WORD_W = 16;

  // Lit-high glyphs, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_MINUS = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  // One-hot digit-select byte for a digit index (always active-high)
  function automatic logic [7:0] digit_select(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational 4-bit code + decimal point to lit-high segment byte.
// Codes 0-9 are digits, 0xA is a minus sign, 0xB-0xF are blank.
module seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  // Look up the glyph and OR in the decimal point
  always_comb begin
    glyph = SEG_BLANK;
    case (code)
      4'h0:    glyph = SEG_0;
      4'h1:    glyph = SEG_1;
      4'h2:    glyph = SEG_2;
      4'h3:    glyph = SEG_3;
      4'h4:    glyph = SEG_4;
      4'h5:    glyph = SEG_5;
      4'h6:    glyph = SEG_6;
      4'h7:    glyph = SEG_7;
      4'h8:    glyph = SEG_8;
      4'h9:    glyph = SEG_9;
      4'hA:    glyph = SEG_MINUS;
      default: glyph = SEG_BLANK;
    endcase
    seg = glyph | {dp, 7'b000_0000};
  end

endmodule

// File: rtl/shift_display_driver.sv
// Multiplexed seven-segment driver feeding a chain of two 595-style shift
// registers. Each digit sends a 16-bit word {segments, digit-select} MSB
// first on sclk/dio, then pulses rlck. Inputs are snapshotted once per frame.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module shift_display_driver
  import display_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp,
  output logic                  sclk,
  output logic                  rlck,
  output logic                  dio,
  output logic                  frame_done
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DIGITS - 1);
  localparam logic [3:0]       BIT_LAST = 4'(WORD_W - 1);

  // Control state
  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;
  logic [3:0]       bit_q, bit_d;

  // Registered pin drivers
  logic sclk_q, sclk_d;
  logic rlck_q, rlck_d;
  logic dio_q, dio_d;
  logic fd_q, fd_d;

  // Datapath: frame snapshot and outgoing shift word
  logic [4*DIGITS-1:0] bcd_sh_q, bcd_sh_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [WORD_W-1:0]   word_q, word_d;

  logic                snap_en;
  logic                half_end;
  logic [4*DIGITS-1:0] src_bcd;
  logic [DIGITS-1:0]   src_dp;
  logic [3:0]          cur_code;
  logic                cur_dp;
  logic                blank;
  logic [7:0]          seg_lit;
  logic [7:0]          seg_pol;
  logic [WORD_W-1:0]   word_load;

  // Last cycle of the current sclk / rlck half-period
  assign half_end = (div_q == DIV_LAST);

  // Digit 0 reads the live inputs (the snapshot is taken in that same LOAD);
  // later digits of the frame read the snapshot
  always_comb begin
    src_bcd  = (idx_q == 3'd0) ? bcd : bcd_sh_q;
    src_dp   = (idx_q == 3'd0) ? dp  : dp_sh_q;
    cur_code = 4'd0;
    cur_dp   = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_code = src_bcd[4*i +: 4];
        cur_dp   = src_dp[i];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the top digit down; a digit is blank while every digit above
  // and including it is zero with no dp. Digit 0 always shows.
  always_comb begin
    logic lead_zero;
    lead_zero = 1'b1;
    blank     = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if ((src_bcd[4*i +: 4] != 4'd0) || src_dp[i]) lead_zero = 1'b0;
      if ((idx_q == 3'(i)) && (i != 0)) blank = lead_zero;
    end
  end
`else
  assign blank = 1'b0;
`endif

  seg_decoder u_seg_decoder (
    .code (cur_code),
    .dp   (cur_dp),
    .seg  (seg_lit)
  );

  // Apply blanking and the module's segment polarity, then form the word
  always_comb begin
    seg_pol = blank ? SEG_BLANK : seg_lit;
    if (SEG_ACTIVE_LOW != 0) seg_pol = ~seg_pol;
    word_load = {seg_pol, digit_select(idx_q)};
  end

  // Next-state and counter logic for the scan FSM
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    snap_en = 1'b0;
    word_d  = word_q;
    case (state_q)
      IDLE: begin
        idx_d   = 3'd0;
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = 4'd0;
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        snap_en = (idx_q == 3'd0);
        word_d  = word_load;
        div_d   = '0;
        phase_d = 1'b0;
        bit_d   = 4'd0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (half_end) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (bit_q == BIT_LAST) begin
              state_d = LATCH;
            end else begin
              bit_d  = bit_q + 4'd1;
              word_d = {word_q[WORD_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        if (half_end) begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (phase_q) begin
            if (!enable) begin
              idx_d   = 3'd0;
              state_d = IDLE;
            end else if (idx_q == IDX_LAST) begin
              idx_d   = 3'd0;
              state_d = LOAD;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = LOAD;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin values per state: sclk low-then-high per bit with dio held for the
  // whole bit, rlck high-then-low during LATCH, frame_done on the final exit
  always_comb begin
    sclk_d = 1'b0;
    rlck_d = 1'b0;
    dio_d  = 1'b0;
    fd_d   = 1'b0;
    case (state_q)
      SHIFT: begin
        sclk_d = phase_q;
        dio_d  = word_q[WORD_W-1];
      end
      LATCH: begin
        rlck_d = ~phase_q;
        fd_d   = half_end & phase_q & enable & (idx_q == IDX_LAST);
      end
      default: ;
    endcase
  end

  // Snapshot mux for the frame shadow registers
  always_comb begin
    bcd_sh_d = snap_en ? bcd : bcd_sh_q;
    dp_sh_d  = snap_en ? dp  : dp_sh_q;
  end

  // Control and pin registers; clear_n returns everything to idle at once
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      div_q   <= '0;
      phase_q <= 1'b0;
      bit_q   <= 4'd0;
      sclk_q  <= 1'b0;
      rlck_q  <= 1'b0;
      dio_q   <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      rlck_q  <= rlck_d;
      dio_q   <= dio_d;
      fd_q    <= fd_d;
    end
  end

  // Data registers need no reset: each is written in LOAD before it is read
  always_ff @(posedge clk) begin
    bcd_sh_q <= bcd_sh_d;
    dp_sh_q  <= dp_sh_d;
    word_q   <= word_d;
  end

  assign sclk       = sclk_q;
  assign rlck       = rlck_q;
  assign dio        = dio_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_shift_display_driver.sv
// Bench for shift_display_driver: two instances (CLK_DIV=1 active-low and
// CLK_DIV=3 active-high). A pin-level 595 model rebuilds each latched word.
module tb_shift_display_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear_n, clear_n_b, enable, enable_b;
  logic [15:0] bcd, bcd_b;
  logic [3:0]  dp, dp_b;
  logic        sclk_a, rlck_a, dio_a, fd_a;
  logic        sclk_b, rlck_b, dio_b, fd_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] GLYPH [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] LZ_SEG = 8'hFF;
`else
  localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

  logic [15:0] wq_a[$], wq_b[$];
  int          rq_a[$], rq_b[$];
  int          fdt_a[$], fdt_b[$];
  logic [15:0] sr_a, sr_b;
  int          rises_a, rises_b;
  logic        ps_a, pr_a, ps_b, pr_b;

  shift_display_driver #(.DIGITS(4), .CLK_DIV(1), .SEG_ACTIVE_LOW(1)) dut_a (
    .clk(clk), .clear_n(clear_n), .enable(enable), .bcd(bcd), .dp(dp),
    .sclk(sclk_a), .rlck(rlck_a), .dio(dio_a), .frame_done(fd_a));

  shift_display_driver #(.DIGITS(4), .CLK_DIV(3), .SEG_ACTIVE_LOW(0)) dut_b (
    .clk(clk), .clear_n(clear_n_b), .enable(enable_b), .bcd(bcd_b), .dp(dp_b),
    .sclk(sclk_b), .rlck(rlck_b), .dio(dio_b), .frame_done(fd_b));

  always @(posedge clk) cyc <= cyc + 1;

  // 595 chain model for instance A: shift on sclk rise, capture on rlck rise
  always @(negedge clk) begin
    if (!clear_n) begin
      sr_a <= '0; rises_a <= 0; ps_a <= 1'b0; pr_a <= 1'b0;
    end else begin
      ps_a <= sclk_a;
      pr_a <= rlck_a;
      if (sclk_a && !ps_a) begin sr_a <= {sr_a[14:0], dio_a}; rises_a <= rises_a + 1; end
      if (rlck_a && !pr_a) begin wq_a.push_back(sr_a); rq_a.push_back(rises_a); rises_a <= 0; end
      if (fd_a) fdt_a.push_back(cyc);
    end
  end

  // 595 chain model for instance B
  always @(negedge clk) begin
    if (!clear_n_b) begin
      sr_b <= '0; rises_b <= 0; ps_b <= 1'b0; pr_b <= 1'b0;
    end else begin
      ps_b <= sclk_b;
      pr_b <= rlck_b;
      if (sclk_b && !ps_b) begin sr_b <= {sr_b[14:0], dio_b}; rises_b <= rises_b + 1; end
      if (rlck_b && !pr_b) begin wq_b.push_back(sr_b); rq_b.push_back(rises_b); rises_b <= 0; end
      if (fd_b) fdt_b.push_back(cyc);
    end
  end

  // Expected word for digit d from the display rules
  function automatic logic [15:0] model_word(input logic [15:0] b, input logic [3:0] p,
                                             input int d, input bit act_low);
    logic [7:0] seg;
    bit         blank;
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (d != 0) begin
      blank = 1'b1;
      for (int k = 3; k >= d; k--)
        if (b[4*k +: 4] != 4'd0 || p[k]) blank = 1'b0;
    end
`endif
    seg = blank ? 8'h00 : (GLYPH[b[4*d +: 4]] | {p[d], 7'b0});
    if (act_low) seg = ~seg;
    return {seg, 8'(1 << d)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int wsize(input bit b);
    return b ? wq_b.size() : wq_a.size();
  endfunction

  function automatic int fsize(input bit b);
    return b ? fdt_b.size() : fdt_a.size();
  endfunction

  task automatic wait_words(input bit b, input int n, input int budget, input string tag);
    int c = 0;
    while (wsize(b) < n && c < budget) begin @(posedge clk); c++; end
    check(tag, 32'(wsize(b) >= n), 32'd1);
  endtask

  task automatic wait_fd(input bit b, input int n, input int budget, input string tag);
    int c = 0;
    while (fsize(b) < n && c < budget) begin @(posedge clk); c++; end
    check(tag, 32'(fsize(b) >= n), 32'd1);
  endtask

  task automatic check_word_a(input int i, input logic [15:0] exp, input string tag);
    logic [31:0] obs;
    obs = (i < wq_a.size()) ? {16'h0, wq_a[i]} : 32'hDEAD_BEEF;
    check(tag, obs, {16'h0, exp});
  endtask

  task automatic check_rises_a(input int i, input string tag);
    logic [31:0] obs;
    obs = (i < rq_a.size()) ? 32'(rq_a[i]) : 32'hDEAD_BEEF;
    check(tag, obs, 32'd16);
  endtask

  task automatic flush_a();
    wq_a.delete();
    rq_a.delete();
  endtask

  task automatic go_idle_a();
    @(negedge clk);
    enable = 1'b0;
    repeat (80) @(negedge clk);
  endtask

  initial begin
    logic [15:0] old_v, new_v;
    logic [3:0]  new_p;
    int          fd0, c;

    clear_n = 1'b0; clear_n_b = 1'b0; enable = 1'b0; enable_b = 1'b0;
    bcd = 16'h0; dp = 4'h0; bcd_b = 16'h509A; dp_b = 4'b0001;
    repeat (3) @(negedge clk);
    check("reset_sclk", 32'(sclk_a), 32'd0);
    check("reset_rlck", 32'(rlck_a), 32'd0);
    check("reset_dio",  32'(dio_a),  32'd0);
    check("reset_fd",   32'(fd_a),   32'd0);

    // Directed word content, two frames, and frame spacing
    @(negedge clk);
    clear_n = 1'b1; clear_n_b = 1'b1;
    bcd = 16'h1234; dp = 4'h0; enable = 1'b1; enable_b = 1'b1;
    wait_words(1'b0, 8, 400, "wait_words_1234");
    check_word_a(0, 16'h9901, "word_1234_d0");
    check_word_a(1, 16'hB002, "word_1234_d1");
    check_word_a(2, 16'hA404, "word_1234_d2");
    check_word_a(3, 16'hF908, "word_1234_d3");
    for (int i = 0; i < 8; i++) check_rises_a(i, $sformatf("rises_a_%0d", i));
    for (int i = 4; i < 8; i++)
      check_word_a(i, model_word(16'h1234, 4'h0, i - 4, 1'b1), $sformatf("word_1234_f2_%0d", i));
    wait_fd(1'b0, 2, 200, "wait_fd_a");
    check("fd_spacing_div1", (fdt_a.size() >= 2) ? 32'(fdt_a[1] - fdt_a[0]) : 32'hDEAD_BEEF, 32'd140);

    // Instance B: CLK_DIV=3, active-high segments
    wait_words(1'b1, 4, 1000, "wait_words_b");
    for (int i = 0; i < 4; i++)
      check($sformatf("word_b_d%0d", i), (i < wq_b.size()) ? {16'h0, wq_b[i]} : 32'hDEAD_BEEF,
            {16'h0, model_word(16'h509A, 4'b0001, i, 1'b0)});
    check("word_b_minus_dp", (wq_b.size() > 0) ? {16'h0, wq_b[0]} : 32'hDEAD_BEEF, 32'h0000_C001);
    check("rises_b_0", (rq_b.size() > 0) ? 32'(rq_b[0]) : 32'hDEAD_BEEF, 32'd16);
    wait_fd(1'b1, 2, 1000, "wait_fd_b");
    check("fd_spacing_div3", (fdt_b.size() >= 2) ? 32'(fdt_b[1] - fdt_b[0]) : 32'hDEAD_BEEF, 32'd412);
    enable_b = 1'b0;

    // Snapshot: change bcd during digit 2 of a frame
    fd0 = fdt_a.size();
    wait_fd(1'b0, fd0 + 1, 200, "wait_frame_start");
    flush_a();
    old_v = 16'h1234;
    wait_words(1'b0, 2, 200, "wait_mid_frame");
    @(negedge clk);
    new_v = {4'h9, 12'($urandom)};
    new_p = 4'($urandom_range(0, 15));
    bcd = new_v; dp = new_p;
    wait_words(1'b0, 8, 400, "wait_snapshot");
    for (int i = 0; i < 4; i++)
      check_word_a(i, model_word(old_v, 4'h0, i, 1'b1), $sformatf("snap_old_d%0d", i));
    for (int i = 0; i < 4; i++)
      check_word_a(i + 4, model_word(new_v, new_p, i, 1'b1), $sformatf("snap_new_d%0d", i));
    go_idle_a();

    // Randomized frames against the reference model
    for (int r = 0; r < 5; r++) begin
      flush_a();
      @(negedge clk);
      bcd = 16'($urandom);
      dp  = 4'($urandom_range(0, 15));
      enable = 1'b1;
      wait_words(1'b0, 4, 200, $sformatf("wait_rand_%0d", r));
      for (int i = 0; i < 4; i++)
        check_word_a(i, model_word(bcd, dp, i, 1'b1), $sformatf("rand_%0d_d%0d", r, i));
      go_idle_a();
    end

    // Enable dropped in the middle of digit 1
    flush_a();
    fd0 = fdt_a.size();
    @(negedge clk);
    bcd = 16'h1234; dp = 4'h0; enable = 1'b1;
    wait_words(1'b0, 1, 100, "wait_en_d0");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (150) @(negedge clk);
    check("en_drop_words", 32'(wq_a.size()), 32'd2);
    check_word_a(1, 16'hB002, "en_drop_d1");
    check("en_drop_no_fd", 32'(fdt_a.size()), 32'(fd0));
    check("en_drop_idle_pins", {28'h0, sclk_a, rlck_a, dio_a, fd_a}, 32'h0);

    // Leading zeros
    flush_a();
    @(negedge clk);
    bcd = 16'h0007; dp = 4'h0; enable = 1'b1;
    wait_words(1'b0, 4, 200, "wait_lz");
    check_word_a(0, 16'hF801, "lz_d0");
    check_word_a(1, {LZ_SEG, 8'h02}, "lz_d1");
    check_word_a(2, {LZ_SEG, 8'h04}, "lz_d2");
    check_word_a(3, {LZ_SEG, 8'h08}, "lz_d3");
    go_idle_a();

    // Special codes: minus with dp, and a blank code
    flush_a();
    @(negedge clk);
    bcd = 16'h00CA; dp = 4'b0001; enable = 1'b1;
    wait_words(1'b0, 2, 200, "wait_special");
    check_word_a(0, 16'h3F01, "special_minus_dp");
    check_word_a(1, 16'hFF02, "special_blank_c");
    go_idle_a();

    // Reset asserted mid-shift while sclk is high
    flush_a();
    @(negedge clk);
    bcd = 16'h1234; dp = 4'h0; enable = 1'b1;
    wait_words(1'b0, 1, 100, "wait_pre_reset");
    repeat (4) @(negedge clk);
    c = 0;
    while (!sclk_a && c < 10) begin @(negedge clk); c++; end
    check("pre_reset_sclk_high", 32'(sclk_a), 32'd1);
    clear_n = 1'b0;
    #1;
    check("async_reset_pins", {28'h0, sclk_a, rlck_a, dio_a, fd_a}, 32'h0);
    repeat (3) @(negedge clk);
    flush_a();
    check("reset_held_pins", {28'h0, sclk_a, rlck_a, dio_a, fd_a}, 32'h0);
    clear_n = 1'b1;
    wait_words(1'b0, 1, 100, "wait_post_reset");
    check_word_a(0, 16'h9901, "post_reset_d0");
    check_rises_a(0, "post_reset_rises");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
